// File: rtl/microsequencer_if.sv
// Microcode store bus: the sequencer presents an address, the store returns
// the decoded control fields of the word at that address (asynchronous read).
// Ports: master = sequencer (drives address), slave = microcode store (drives fields).
interface microsequencer_if #(
  parameter int NUM_ADDRESS_LINES = 5,
  parameter int NUM_VARSEL_BITS   = 3,
  parameter int NUM_TIMERS        = 2,
  parameter int NUM_SWITCH_BITS   = 1
);
  logic [NUM_ADDRESS_LINES-1:0] address;
  logic [NUM_ADDRESS_LINES-1:0] jadr;
  logic [NUM_VARSEL_BITS-1:0]   varSel;
  logic [NUM_TIMERS-1:0]        timerSel;
  logic [NUM_TIMERS-1:0]        timerLd;
  logic [NUM_SWITCH_BITS-1:0]   switch_sel;
  logic                         switch_active;
  logic                         var_or_timer;
  logic                         branch;
  logic                         forced_jmp;
  logic                         sub;
  logic                         rtn;

  modport master (
    output address,
    input  jadr, varSel, timerSel, timerLd, switch_sel,
    input  switch_active, var_or_timer, branch, forced_jmp, sub, rtn
  );

  modport slave (
    input  address,
    output jadr, varSel, timerSel, timerLd, switch_sel,
    output switch_active, var_or_timer, branch, forced_jmp, sub, rtn
  );
endinterface

// File: rtl/microsequencer.sv
// Microcode next-address generator with condition mux, down-counter timers and return stack.
// Latency: one microinstruction per clock; the next address is registered on each posedge.
// Backpressure: ready=0 forces address 0; hold=1 freezes address/stack/flags while timers run.
// Ports: clk, rst (async active-high); ready, hold; variables, timer_values, switch_values
//        (condition/timer/switch sources); ucode (address out, control fields in);
//        timer_done, stack_overflow, stack_underflow (status out).
module microsequencer #(
  parameter int NUM_ADDRESS_LINES = 5,
  parameter int NUM_VARSEL_BITS   = 3,
  parameter int NUM_TIMERS        = 2,
  parameter int TIMER_WIDTH       = 8,
  parameter int NUM_SWITCH_BITS   = 1,
  parameter int SWITCH_WIDTH      = 3,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         ready,
  input  logic                                         hold,
  input  logic [(2**NUM_VARSEL_BITS)-1:0]              variables,
  input  logic [NUM_TIMERS*TIMER_WIDTH-1:0]            timer_values,
  input  logic [(2**NUM_SWITCH_BITS)*SWITCH_WIDTH-1:0] switch_values,
  microsequencer_if.master                             ucode,
  output logic [NUM_TIMERS-1:0]                        timer_done,
  output logic                                         stack_overflow,
  output logic                                         stack_underflow
);
  localparam int NUM_SWITCH = 2**NUM_SWITCH_BITS;
  localparam int SPW        = $clog2(STACK_DEPTH + 1);
  localparam int IDXW       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [NUM_ADDRESS_LINES-1:0] addr_q;
  logic [NUM_ADDRESS_LINES-1:0] next_addr;
  logic [NUM_ADDRESS_LINES-1:0] ret_addr;
  logic [NUM_ADDRESS_LINES-1:0] stack_mem [STACK_DEPTH];
  logic [SPW-1:0]               sp_q;
  logic [IDXW-1:0]              top_idx;
  logic [SWITCH_WIDTH-1:0]      sw_val;
  logic [TIMER_WIDTH-1:0]       count_q [NUM_TIMERS];
  logic                         stack_empty, stack_full;
  logic                         cond;
  logic                         push, pop, set_ovf, set_unf;
  logic                         advance;

  assign ucode.address = addr_q;
  assign ret_addr      = addr_q + 1'b1;
  assign stack_empty   = (sp_q == '0);
  assign stack_full    = (sp_q == SPW'(STACK_DEPTH));
  assign top_idx       = IDXW'(sp_q - 1'b1);
  assign advance       = ready && !hold;

  // Timers run whenever the store is ready; hold only stalls the address path.
  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q[i] <= '0;
      end else if (ready) begin
        if (ucode.timerLd[i]) begin
          count_q[i] <= timer_values[i*TIMER_WIDTH +: TIMER_WIDTH];
        end else if (count_q[i] != '0) begin
          count_q[i] <= count_q[i] - 1'b1;
        end
      end
    end
    assign timer_done[i] = (count_q[i] == '0);
  end

  assign cond = ucode.var_or_timer ? |(ucode.timerSel & timer_done)
                                   : variables[ucode.varSel];

  always_comb begin
    sw_val = '0;
    for (int s = 0; s < NUM_SWITCH; s++) begin
      if (ucode.switch_sel == NUM_SWITCH_BITS'(s)) begin
        sw_val = switch_values[s*SWITCH_WIDTH +: SWITCH_WIDTH];
      end
    end
  end

  // Next-address selection in priority order: return, switch, call, jump, branch, sequential.
  always_comb begin
    next_addr = ret_addr;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (ucode.rtn) begin
      if (stack_empty) begin
        next_addr = '0;
        set_unf   = 1'b1;
      end else begin
        next_addr = stack_mem[top_idx];
        pop       = 1'b1;
      end
    end else if (ucode.switch_active) begin
      next_addr = ucode.jadr + NUM_ADDRESS_LINES'(sw_val);
    end else if (ucode.sub) begin
      // The call still jumps when the stack is full; only the push is lost.
      next_addr = ucode.jadr;
      if (stack_full) begin
        set_ovf = 1'b1;
      end else begin
        push = 1'b1;
      end
    end else if (ucode.forced_jmp) begin
      next_addr = ucode.jadr;
    end else if (ucode.branch && cond) begin
      next_addr = ucode.jadr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q          <= '0;
      sp_q            <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!ready) begin
      addr_q <= '0;
    end else if (!hold) begin
      addr_q <= next_addr;
      if (push) begin
        sp_q <= sp_q + 1'b1;
      end else if (pop) begin
        sp_q <= sp_q - 1'b1;
      end
      if (set_ovf) stack_overflow  <= 1'b1;
      if (set_unf) stack_underflow <= 1'b1;
    end
  end

  // Stack contents need no reset: the pointer alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (advance && push) begin
      stack_mem[sp_q[IDXW-1:0]] <= ret_addr;
    end
  end
endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: a small ROM model drives the control fields
// from the current address, and each step compares the registered address and
// status outputs against hand-computed values.
module tb_microsequencer;
  typedef struct packed {
    logic [4:0] jadr;
    logic [2:0] var_sel;
    logic [1:0] timer_sel;
    logic [1:0] timer_ld;
    logic       switch_sel;
    logic       switch_active;
    logic       var_or_timer;
    logic       branch;
    logic       forced_jmp;
    logic       sub;
    logic       rtn;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  variables = '0;
  logic [15:0] timer_values = '0;
  logic [5:0]  switch_values = '0;
  logic [1:0]  timer_done;
  logic        stack_overflow;
  logic        stack_underflow;
  word_t       rom [32];
  int          n_checks = 0;
  int          n_fail = 0;

  microsequencer_if bus ();

  assign bus.jadr          = rom[bus.address].jadr;
  assign bus.varSel        = rom[bus.address].var_sel;
  assign bus.timerSel      = rom[bus.address].timer_sel;
  assign bus.timerLd       = rom[bus.address].timer_ld;
  assign bus.switch_sel    = rom[bus.address].switch_sel;
  assign bus.switch_active = rom[bus.address].switch_active;
  assign bus.var_or_timer  = rom[bus.address].var_or_timer;
  assign bus.branch        = rom[bus.address].branch;
  assign bus.forced_jmp    = rom[bus.address].forced_jmp;
  assign bus.sub           = rom[bus.address].sub;
  assign bus.rtn           = rom[bus.address].rtn;

  microsequencer dut (
    .clk             (clk),
    .rst             (rst),
    .ready           (ready),
    .hold            (hold),
    .variables       (variables),
    .timer_values    (timer_values),
    .switch_values   (switch_values),
    .ucode           (bus),
    .timer_done      (timer_done),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input int exp_addr);
    tick();
    check(tag, 32'(bus.address), 32'(exp_addr));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    ready = 1'b0;
    hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = 1'b1;
  endtask

  initial begin
    clear_rom();

    // Reset state
    apply_reset();
    check("reset_addr", 32'(bus.address), 32'd0);
    check("reset_timer_done", 32'(timer_done), 32'd3);
    check("reset_ovf", 32'(stack_overflow), 32'd0);
    check("reset_unf", 32'(stack_underflow), 32'd0);

    // Sequential stepping with wrap at 31
    for (int i = 1; i <= 33; i++) step_check("seq", i % 32);
    step_check("seq_more", 2);
    ready = 1'b0;
    step_check("not_ready_zero", 0);
    ready = 1'b1;
    step_check("ready_again", 1);

    // Conditional branch taken / not taken
    clear_rom();
    rom[4].branch = 1'b1; rom[4].var_sel = 3'd5; rom[4].jadr = 5'd20;
    variables = 8'h20;
    apply_reset();
    for (int i = 1; i <= 4; i++) step_check("br_pre", i);
    step_check("br_taken", 20);
    variables = 8'hDF;
    apply_reset();
    for (int i = 1; i <= 4; i++) step_check("br_pre2", i);
    step_check("br_not_taken", 5);

    // Simple call / return
    clear_rom();
    rom[2].sub = 1'b1; rom[2].jadr = 5'd10;
    rom[10].rtn = 1'b1;
    apply_reset();
    step_check("call_1", 1);
    step_check("call_2", 2);
    step_check("call_target", 10);
    step_check("call_return", 3);
    check("call_ovf", 32'(stack_overflow), 32'd0);
    check("call_unf", 32'(stack_underflow), 32'd0);

    // Five nested calls on a 4-deep stack
    clear_rom();
    rom[0].sub = 1'b1;  rom[0].jadr = 5'd5;
    rom[5].sub = 1'b1;  rom[5].jadr = 5'd10;
    rom[10].sub = 1'b1; rom[10].jadr = 5'd15;
    rom[15].sub = 1'b1; rom[15].jadr = 5'd20;
    rom[20].sub = 1'b1; rom[20].jadr = 5'd25;
    rom[25].rtn = 1'b1; rom[16].rtn = 1'b1; rom[11].rtn = 1'b1; rom[6].rtn = 1'b1;
    apply_reset();
    step_check("nest_5", 5);
    step_check("nest_10", 10);
    step_check("nest_15", 15);
    step_check("nest_20", 20);
    check("nest_ovf_before", 32'(stack_overflow), 32'd0);
    step_check("nest_25", 25);
    check("nest_ovf_after", 32'(stack_overflow), 32'd1);
    step_check("nest_ret_16", 16);
    step_check("nest_ret_11", 11);
    step_check("nest_ret_6", 6);
    step_check("nest_ret_1", 1);
    step_check("nest_seq_2", 2);
    check("nest_unf", 32'(stack_underflow), 32'd0);
    check("nest_ovf_sticky", 32'(stack_overflow), 32'd1);

    // Return on empty stack, sticky underflow, asynchronous reset
    clear_rom();
    rom[7].rtn = 1'b1;
    apply_reset();
    for (int i = 1; i <= 7; i++) step_check("unf_pre", i);
    step_check("unf_to_zero", 0);
    check("unf_set", 32'(stack_underflow), 32'd1);
    for (int i = 1; i <= 3; i++) step_check("unf_again", i);
    check("unf_sticky", 32'(stack_underflow), 32'd1);
    check("unf_no_ovf", 32'(stack_overflow), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_addr", 32'(bus.address), 32'd0);
    check("async_rst_unf", 32'(stack_underflow), 32'd0);

    // Timer polling loop: load 3, wait for timer 1
    clear_rom();
    timer_values = {8'd3, 8'd0};
    rom[0].timer_ld = 2'b10;
    rom[1].branch = 1'b1; rom[1].var_or_timer = 1'b1; rom[1].timer_sel = 2'b10; rom[1].jadr = 5'd20;
    rom[2].forced_jmp = 1'b1; rom[2].jadr = 5'd1;
    apply_reset();
    step_check("tmr_a1", 1);
    check("tmr_done_loaded", 32'(timer_done), 32'd1);
    step_check("tmr_a2", 2);
    step_check("tmr_a3", 1);
    check("tmr_done_running", 32'(timer_done), 32'd1);
    step_check("tmr_a4", 2);
    check("tmr_done_expired", 32'(timer_done), 32'd3);
    step_check("tmr_a5", 1);
    step_check("tmr_exit", 20);

    // Same loop with a two-cycle hold: timer still expires on schedule
    apply_reset();
    step_check("tmrh_a1", 1);
    hold = 1'b1;
    step_check("tmrh_hold1", 1);
    step_check("tmrh_hold2", 1);
    check("tmrh_done_held", 32'(timer_done), 32'd1);
    hold = 1'b0;
    step_check("tmrh_a4", 2);
    check("tmrh_done_expired", 32'(timer_done), 32'd3);
    step_check("tmrh_a5", 1);
    step_check("tmrh_exit", 20);

    // Switch jumps, forced jump, return-over-call priority
    clear_rom();
    switch_values = {3'd3, 3'd5};
    rom[0].switch_active = 1'b1; rom[0].switch_sel = 1'b1; rom[0].jadr = 5'd8;
    rom[11].switch_active = 1'b1; rom[11].sub = 1'b1; rom[11].switch_sel = 1'b0; rom[11].jadr = 5'd30;
    rom[3].forced_jmp = 1'b1; rom[3].jadr = 5'd17;
    rom[17].rtn = 1'b1; rom[17].sub = 1'b1; rom[17].jadr = 5'd9;
    apply_reset();
    step_check("sw_add", 11);
    step_check("sw_wrap", 3);
    step_check("fjmp", 17);
    step_check("rtn_over_sub", 0);
    check("rtn_over_sub_unf", 32'(stack_underflow), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
